// File: rtl/psum_ofifo_pkg.sv
// Array-wide constants shared by the south-edge psum output collector.
package psum_ofifo_pkg;

   localparam int unsigned col_dflt     = 8;
   localparam int unsigned psum_bw_dflt = 16;
   localparam int unsigned depth_dflt   = 16;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

   localparam int unsigned ptr_w_dflt = ptr_width(depth_dflt);

endpackage

// File: rtl/psum_ofifo_if.sv
// Row-level bus between the array south edge, the collector and its downstream reader.
interface psum_ofifo_if
   import psum_ofifo_pkg::*;
#(
   parameter int unsigned col     = col_dflt,
   parameter int unsigned psum_bw = psum_bw_dflt
);

   logic [psum_bw*col-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [psum_bw*col-1:0] out;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_ready;
   logic [col-1:0]         overflow;

   // Array side and reader side together drive the collector.
   modport master (
      output in, wr, rd,
      input  out, o_valid, o_full, o_ready, overflow
   );

   modport slave (
      input  in, wr, rd,
      output out, o_valid, o_full, o_ready, overflow
   );

endinterface

// File: rtl/psum_fifo_col.sv
// One column FIFO: storage, pointers, occupancy count, full/empty decode and sticky overflow.
module psum_fifo_col
   import psum_ofifo_pkg::*;
#(
   parameter int unsigned psum_bw = psum_bw_dflt,
   parameter int unsigned depth   = depth_dflt
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [psum_bw-1:0] wdata,
   input  logic               wr,
   input  logic               pop,
   output logic [psum_bw-1:0] rdata_c,
   output logic               empty_c,
   output logic               full_c,
   output logic               overflow
);

   localparam int unsigned ptr_w = ptr_width(depth);
   localparam int unsigned cnt_w = ptr_w + 1;

   logic [ptr_w-1:0]   wptr;
   logic [ptr_w-1:0]   rptr;
   logic [cnt_w-1:0]   count;
   logic [psum_bw-1:0] mem [depth];

   logic pop_ok_c;
   logic accept_c;

   assign empty_c  = (count == '0);
   assign full_c   = (count == cnt_w'(depth));
   // A full column still takes a write when the same cycle frees a slot.
   assign pop_ok_c = pop && !empty_c;
   assign accept_c = wr && (!full_c || pop_ok_c);
   assign rdata_c  = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept_c) begin
            wptr <= wptr + ptr_w'(1);
         end
         if (pop_ok_c) begin
            rptr <= rptr + ptr_w'(1);
         end
         count <= count + cnt_w'(accept_c) - cnt_w'(pop_ok_c);
         if (wr && !accept_c) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; writes coinciding with reset are dropped.
   always_ff @(posedge clk) begin
      if (!reset && accept_c) begin
         mem[wptr] <= wdata;
      end
   end

endmodule

// File: rtl/psum_ofifo.sv
// South-edge output collector: per-column FIFOs deskew array results into whole rows.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int unsigned col     = col_dflt,
   parameter int unsigned psum_bw = psum_bw_dflt,
   parameter int unsigned depth   = depth_dflt
) (
   input  logic           clk,
   input  logic           reset,
   psum_ofifo_if.slave    bus
);

   logic [col-1:0]     empty_c;
   logic [col-1:0]     full_c;
   logic [psum_bw-1:0] rdata_c [col];
   logic               valid_c;
   logic               pop_c;

   // A row exists only when every column holds at least one result.
   assign valid_c = ~|empty_c;
   assign pop_c   = bus.rd && valid_c;

   assign bus.o_valid = valid_c;
   assign bus.o_full  = |full_c;
   assign bus.o_ready = ~|full_c;

   for (genvar i = 0; i < int'(col); i++) begin : g_col
      psum_fifo_col #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_col (
         .clk      (clk),
         .reset    (reset),
         .wdata    (bus.in[psum_bw*i +: psum_bw]),
         .wr       (bus.wr[i]),
         .pop      (pop_c),
         .rdata_c  (rdata_c[i]),
         .empty_c  (empty_c[i]),
         .full_c   (full_c[i]),
         .overflow (bus.overflow[i])
      );

      assign bus.out[psum_bw*i +: psum_bw] = valid_c ? rdata_c[i] : '0;
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized and directed scoreboard bench for psum_ofifo against a queue-based row model.
module tb_psum_ofifo;

   localparam int unsigned COL   = 8;
   localparam int unsigned BW    = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned W     = COL * BW;

   logic clk;
   logic rst;

   psum_ofifo_if #(.col(COL), .psum_bw(BW)) bus ();

   psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [BW-1:0] colq_t [$];
   typedef struct {
      bit             chk;
      logic           valid;
      logic           full;
      logic [COL-1:0] ovf;
      logic [W-1:0]   out;
   } exp_t;

   colq_t          mq [COL];
   logic [COL-1:0] movf;
   bit             known;
   exp_t           exp_q [$];
   int             checks;
   int             errors;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected visible state derived from the column queues.
   function automatic exp_t model_view();
      exp_t e;
      e.chk   = known;
      e.valid = 1'b1;
      e.full  = 1'b0;
      e.ovf   = movf;
      e.out   = '0;
      for (int i = 0; i < int'(COL); i++) begin
         if (mq[i].size() == 0) e.valid = 1'b0;
         if (mq[i].size() == int'(DEPTH)) e.full = 1'b1;
      end
      if (e.valid) begin
         for (int i = 0; i < int'(COL); i++) e.out[BW*i +: BW] = mq[i][0];
      end
      return e;
   endfunction

   task automatic model_update(input logic r_rst, input logic [COL-1:0] w,
                               input logic [W-1:0] d, input logic r);
      bit pop;
      if (r_rst) begin
         for (int i = 0; i < int'(COL); i++) mq[i].delete();
         movf  = '0;
         known = 1'b1;
         return;
      end
      pop = r;
      for (int i = 0; i < int'(COL); i++) if (mq[i].size() == 0) pop = 1'b0;
      for (int i = 0; i < int'(COL); i++) begin
         bit acc;
         acc = w[i] && (mq[i].size() < int'(DEPTH) || pop);
         if (pop) void'(mq[i].pop_front());
         if (acc) mq[i].push_back(d[BW*i +: BW]);
         else if (w[i]) movf[i] = 1'b1;
      end
   endtask

   // One clock: drive inputs, queue the expected outputs, then advance the model at the edge.
   task automatic step(input logic r_rst, input logic [COL-1:0] w,
                       input logic [W-1:0] d, input logic r);
      rst    = r_rst;
      bus.wr = w;
      bus.in = d;
      bus.rd = r;
      exp_q.push_back(model_view());
      @(posedge clk);
      model_update(r_rst, w, d, r);
      #1;
   endtask

   function automatic logic [W-1:0] row_val(input int r);
      logic [W-1:0] v;
      for (int i = 0; i < int'(COL); i++) v[BW*i +: BW] = BW'(16 * r + i);
      return v;
   endfunction

   function automatic logic [W-1:0] rand_row();
      logic [W-1:0] v;
      for (int i = 0; i < int'(COL); i++) v[BW*i +: BW] = BW'($urandom);
      return v;
   endfunction

   // Monitor: compares every presented cycle against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.chk) begin
            check("o_valid", W'(bus.o_valid), W'(e.valid));
            check("o_full", W'(bus.o_full), W'(e.full));
            check("o_ready", W'(bus.o_ready), W'(!e.full));
            check("overflow", W'(bus.overflow), W'(e.ovf));
            check("out", bus.out, e.out);
         end
      end
   end

   initial begin
      logic [W-1:0] d;
      checks = 0;
      errors = 0;
      known  = 1'b0;
      movf   = '0;
      rst    = 1'b1;
      bus.wr = '0;
      bus.in = '0;
      bus.rd = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      step(1'b1, '0, '0, 1'b0);
      step(1'b1, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);

      // Skewed fill: column c written in cycle c.
      for (int c = 0; c < int'(COL); c++) begin
         d = '0;
         d[BW*c +: BW] = BW'(16'h0100 + c);
         step(1'b0, COL'(1) << c, d, 1'b0);
      end
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);

      // Fill to depth, one dropped write on column 3, drain, then a small wrapping fill/drain.
      for (int r = 0; r < int'(DEPTH); r++) step(1'b0, '1, row_val(r), 1'b0);
      step(1'b0, COL'(8'h08), row_val(99), 1'b0);
      for (int r = 0; r < int'(DEPTH); r++) step(1'b0, '0, '0, 1'b1);
      for (int r = 0; r < 3; r++) step(1'b0, '1, row_val(200 + r), 1'b0);
      for (int r = 0; r < 4; r++) step(1'b0, '0, '0, 1'b1);

      // Streaming while full.
      for (int r = 0; r < int'(DEPTH); r++) step(1'b0, '1, rand_row(), 1'b0);
      for (int r = 0; r < 20; r++) step(1'b0, '1, rand_row(), 1'b1);
      for (int r = 0; r < int'(DEPTH) + 1; r++) step(1'b0, '0, '0, 1'b1);

      // Read with column 7 still empty is ignored.
      step(1'b0, COL'(8'h7F), rand_row(), 1'b0);
      for (int r = 0; r < 3; r++) step(1'b0, '0, '0, 1'b1);
      step(1'b0, COL'(8'h80), rand_row(), 1'b0);
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1);

      // Reset mid-stream with traffic on the inputs.
      for (int r = 0; r < 5; r++) step(1'b0, '1, rand_row(), 1'b0);
      step(1'b1, '1, rand_row(), 1'b1);
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '1, rand_row(), 1'b0);
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0);

      // Random traffic with column skew and rare resets.
      for (int n = 0; n < 400; n++) begin
         logic [COL-1:0] w;
         for (int i = 0; i < int'(COL); i++) w[i] = ($urandom_range(0, 3) != 0);
         step($urandom_range(0, 99) == 0, w, rand_row(), $urandom_range(0, 9) < 6);
      end
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", W'(exp_q.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector at the south edge of the systolic MAC array. It receives the per-column partial sums and per-column valid strobes that the array emits with column skew. Each column's results are buffered in an independent FIFO, so a column's results are held until every column has at least one result. Complete, deskewed rows are then presented to the downstream reader (SRAM writeback / SFU) through a valid/read handshake.

## Interface
- `col`, default 8: number of array columns, one FIFO per column.
- `psum_bw`, default 16: partial-sum width per column.
- `depth`, default 16: entries per column FIFO; must be a power of two, at least 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the next rising edge.
- `in`  in  `psum_bw*col`: array south-edge psums; column i occupies bits `[psum_bw*(i+1)-1 : psum_bw*i]`.
- `wr`  in  `col`: per-column write strobe, wired to the array's per-column valid.
- `rd`  in  1: downstream pops one full row.
- `out`  out  `psum_bw*col`: head row, same column packing as `in`.
- `o_valid`  out  1: every column FIFO is non-empty.
- `o_full`  out  1: at least one column FIFO is full.
- `o_ready`  out  1: equals `!o_full`; upstream issues execute instructions only while this is high.
- `overflow`  out  `col`: sticky per column; set when a write is dropped.

## Operation
- Each column has its own write pointer, read pointer and occupancy count. The count is log2(depth)+1 bits wide.
- **Write, column i:** `wr[i]` is accepted when `count_i < depth`, or when `count_i == depth` and a pop occurs in the same cycle.
  - An accepted write stores `in` slice i at `wptr_i` and advances `wptr_i` modulo depth.
  - A rejected write leaves the FIFO unchanged and sets `overflow[i]`.
- **Pop:** occurs when `rd && o_valid`. All columns advance their read pointers together, modulo depth. `rd` while `o_valid` is low is ignored and has no side effects.
- **Simultaneous write and pop on one column:** the count is unchanged and both pointers advance.
- **Occupancy update:** `count_i` next = `count_i` + accepted write − pop.
- **Output data:** `out` is first-word-fall-through. Each slice is the entry at `rptr_i` while `o_valid` is high, and all-zero while `o_valid` is low.
- **Flags:**
  - `o_valid` = AND over all columns of (`count_i != 0`).
  - `o_full` = OR over all columns of (`count_i == depth`).
  - Both flags are decoded from registered counts.
- **Overflow:** `overflow` bits clear only on reset.
- **Skew:** column i typically receives its k-th result i cycles after column 0. Rows are aligned purely by per-column order; no tagging is used.

## Timing
- **Reset values:** all pointers and counts are 0; `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `overflow` = 0, `out` = 0. Memory contents are not reset.
- **Reset mid-operation:** all buffered data is discarded and the flags above apply the cycle after the reset edge. `wr`/`rd` asserted together with `reset` are ignored.
- **Write to valid latency:** a write in cycle t to the last empty column makes `o_valid` high in cycle t+1, with `out` already showing that data.
- **Pop latency:** a pop in cycle t presents the next row (or `o_valid` low) in cycle t+1.
- **Throughput:** a sustained rate of one row per cycle is supported when all `wr` are high and `rd` is held high.
- **Wrap-around:** pointers wrap from depth−1 to 0 with no bubble.

## Structure
- **Shared package (array-wide constants):** default `col`, `psum_bw`, `depth`, and the pointer width `$clog2(depth)`.
- **Sub-module `psum_fifo_col`:** one column FIFO with pointers, count, storage, full/empty and the overflow bit. It takes an external pop input.
- **`psum_ofifo` top:** instantiates `col` copies of `psum_fifo_col` in a generate loop, broadcasts the pop, and reduces the per-column empty/full flags to `o_valid` and `o_full`.

## Test plan
- **Reset state:** `reset` high for 2 cycles, then `wr = 0` → `o_valid = 0`, `o_ready = 1`, `out = 0`, `overflow = 0`.
- **Skewed fill:** column i writes value 16'h0100+i at cycle i (i = 0..7), with `rd = 0`.
  - `o_valid` rises exactly at cycle 8.
  - `out` = {16'h0107, …, 16'h0100}.
  - One `rd` pulse → `o_valid = 0` the next cycle.
- **Full, overflow and wrap:** write `depth` rows (row r, column i = 16*r+i), then one extra write on column 3.
  - `o_full = 1` and `overflow = 8'b0000_1000`.
  - Draining returns rows 0..depth−1 in order.
  - A following 3-row fill/drain crosses the pointer wrap with the correct data.
- **Streaming at full depth:** while full, all `wr` = 1 and `rd` = 1 for 20 cycles.
  - No overflow is set.
  - Count stays at `depth`.
  - The output sequence equals the input sequence delayed by `depth` rows.
- **Read on empty:** `rd = 1` with only columns 0..6 holding 1 entry.
  - No pop occurs and counts are unchanged.
  - A write to column 7 then raises `o_valid` the next cycle.
- **Reset mid-stream:** assert `reset` with 5 rows buffered and `wr`/`rd` active.
  - Next cycle: `o_valid = 0`, `o_full = 0`, `overflow = 0`.
  - The first row written afterwards is read back first.
